lpf1_mc: RTL

- Synthesizable, multi-channel, fixed-point first-order IIR filter. It is the clocked successor to the behavioural real-valued bilinear-transform LPF model.
- Processes time-interleaved samples from NCH channels through one shared datapath. Per-channel state (previous input, previous output) is held in register arrays.
- Modes: low-pass, high-pass or bypass. Coefficients are loadable at run time.
- Sits between the sampled front-end data stream and downstream decimation/measurement logic.

---
 rtl/lpf1_mc_if.sv | 41 ++++
 rtl/lpf1_mc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lpf1_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : lpf1_mc_if
// Description : Sample, control and result bundle for the multi-channel
//               first-order IIR filter. The master side drives samples,
//               mode, coefficients and clears, and receives filtered results.
// Revision    : 1.0 - initial release
// ============================================================================
interface lpf1_mc_if #(
  parameter int W   = 16,
  parameter int CW  = 18,
  parameter int CHW = 2
);
  // sample stream in
  logic                  in_valid;
  logic [CHW-1:0]        in_ch;
  logic signed [W-1:0]   in;
  // filter control
  logic [1:0]            mode;
  logic                  coef_ld;
  logic signed [CW-1:0]  coef_b0;
  logic signed [CW-1:0]  coef_a1;
  logic                  clr;
  logic [CHW-1:0]        clr_ch;
  // result stream out
  logic                  out_valid;
  logic [CHW-1:0]        out_ch;
  logic signed [W-1:0]   out;
  logic                  sat;

  modport master (
    output in_valid, in_ch, in, mode, coef_ld, coef_b0, coef_a1, clr, clr_ch,
    input  out_valid, out_ch, out, sat
  );

  modport slave (
    input  in_valid, in_ch, in, mode, coef_ld, coef_b0, coef_a1, clr, clr_ch,
    output out_valid, out_ch, out, sat
  );
endinterface
`default_nettype wire

// File: rtl/lpf1_mc.sv
`default_nettype none
// ============================================================================
// Module      : lpf1_mc
// Description : Multi-channel fixed-point first-order IIR (bilinear LPF/HPF)
//               with bypass. Time-interleaved channels share one datapath;
//               previous input/output per channel live in register arrays.
//               y = b0*x + b1*xold - a1*yold, b1 = +b0 (LPF) / -b0 (HPF),
//               rounded half-up, shifted by CF and saturated to W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module lpf1_mc #(
  parameter int W   = 16,
  parameter int CW  = 18,
  parameter int CF  = 16,
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  lpf1_mc_if.slave  bus
);

  // product / accumulator widths
  localparam int c_P0W = W + CW + 1;  // b0 * (x +/- xold)
  localparam int c_P1W = W + CW;      // a1 * yold
  localparam int c_AW  = W + CW + 2;  // full-precision accumulator

  localparam logic [1:0] c_MODE_HPF = 2'b01;

  // half an output LSB, for round-half-up before the shift
  localparam logic signed [c_AW-1:0] c_HALF =
    {{(c_AW-CF){1'b0}}, 1'b1, {(CF-1){1'b0}}};

  // output range, sign-extended to accumulator width for comparison
  localparam logic signed [c_AW-1:0] c_YMAX =
    {{(c_AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [c_AW-1:0] c_YMIN =
    {{(c_AW-W+1){1'b1}}, {(W-1){1'b0}}};

  // per-channel state
  logic signed [W-1:0]   r_xold [NCH];
  logic signed [W-1:0]   r_yold [NCH];

  // active coefficients
  logic signed [CW-1:0]  r_b0;
  logic signed [CW-1:0]  r_a1;

  // registered results
  logic                  r_out_valid;
  logic [CHW-1:0]        r_out_ch;
  logic signed [W-1:0]   r_out;
  logic                  r_sat;

  // datapath wires
  logic                  w_ch_ok;
  logic signed [W-1:0]   w_xo;
  logic signed [W-1:0]   w_yo;
  logic signed [W-1:0]   w_x;
  logic                  w_bypass;
  logic                  w_hpf;
  logic                  w_accept;
  logic signed [W:0]     w_xsum;
  logic signed [c_P0W-1:0] w_b0_ext;
  logic signed [c_P0W-1:0] w_xs_ext;
  logic signed [c_P0W-1:0] w_p0;
  logic signed [c_P1W-1:0] w_a1_ext;
  logic signed [c_P1W-1:0] w_yo_ext;
  logic signed [c_P1W-1:0] w_p1;
  logic signed [c_AW-1:0]  w_acc;
  logic signed [c_AW-1:0]  w_rnd;
  logic signed [c_AW-1:0]  w_shr;
  logic                  w_hi;
  logic                  w_lo;
  logic signed [W-1:0]   w_yflt;
  logic signed [W-1:0]   w_y;
  logic                  w_clip;

  // Select the addressed channel's state; an out-of-range index is flagged
  always_comb begin
    w_ch_ok = 1'b0;
    w_xo    = '0;
    w_yo    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(bus.in_ch) == i) begin
        w_ch_ok = 1'b1;
        w_xo    = r_xold[i];
        w_yo    = r_yold[i];
      end
    end
  end

  assign w_x      = bus.in;
  assign w_bypass = bus.mode[1];           // 10 and 11 both pass through
  assign w_hpf    = (bus.mode == c_MODE_HPF);
  assign w_accept = bus.in_valid & w_ch_ok;

  // b0*x + b1*xold with b1 = +/-b0 folds into one multiply by (x +/- xold);
  // the extra bit keeps the sum exact, and -b0 never has to be formed.
  assign w_xsum = w_hpf ? ({w_x[W-1], w_x} - {w_xo[W-1], w_xo})
                        : ({w_x[W-1], w_x} + {w_xo[W-1], w_xo});

  assign w_b0_ext = {{(W+1){r_b0[CW-1]}}, r_b0};
  assign w_xs_ext = {{CW{w_xsum[W]}}, w_xsum};
  assign w_p0     = w_b0_ext * w_xs_ext;

  assign w_a1_ext = {{W{r_a1[CW-1]}}, r_a1};
  assign w_yo_ext = {{CW{w_yo[W-1]}}, w_yo};
  assign w_p1     = w_a1_ext * w_yo_ext;

  assign w_acc = {w_p0[c_P0W-1], w_p0} - {{2{w_p1[c_P1W-1]}}, w_p1};
  assign w_rnd = w_acc + c_HALF;
  assign w_shr = w_rnd >>> CF;

  // Clip to the W-bit signed range
  assign w_hi   = (w_shr > c_YMAX);
  assign w_lo   = (w_shr < c_YMIN);
  assign w_yflt = w_hi ? c_YMAX[W-1:0] : (w_lo ? c_YMIN[W-1:0] : w_shr[W-1:0]);

  // Bypass forwards the raw sample and never reports a clip
  assign w_y    = w_bypass ? w_x : w_yflt;
  assign w_clip = ~w_bypass & (w_hi | w_lo);

  // Result register: valid pulses per accepted sample, data/channel hold otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out       <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_ch <= bus.in_ch;
        r_out    <= w_y;
        if (w_clip) begin
          r_sat <= 1'b1;
        end
      end
    end
  end

  // Coefficient load; the sample at the same edge already used the old values
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_b0 <= '0;
      r_a1 <= '0;
    end else if (bus.coef_ld) begin
      r_b0 <= bus.coef_b0;
      r_a1 <= bus.coef_a1;
    end
  end

  // Channel state update; a clear on the same channel wins over the sample write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_xold[i] <= '0;
        r_yold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_accept && (int'(bus.in_ch) == i)) begin
          r_xold[i] <= w_x;
          r_yold[i] <= w_y;
        end
        if (bus.clr && (int'(bus.clr_ch) == i)) begin
          r_xold[i] <= '0;
          r_yold[i] <= '0;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_ch    = r_out_ch;
  assign bus.out       = r_out;
  assign bus.sat       = r_sat;

endmodule
`default_nettype wire
